lumini_semafor: RTL and testbench
=================================

# lumini_semafor

Traffic-light phase driver for the intersection. It consumes the 3-bit phase code `stare_semafor` (SUD, EST, VEST, NORD, PIETONI, SERVICE) produced by the phase sequencer. It runs the all-red → green → yellow sequence for the commanded approach, or pedestrian green → blinking green for PIETONI, and drives the lamp outputs. It pulses `ready_S` back to the sequencer when the phase is complete.

## Interface
- `T_ROSU`, default 2: all-red clearance length, in `clk_div` ticks (≥1).
- `T_VERDE`, default 10: vehicle green length, in ticks (≥1).
- `T_GALBEN`, default 3: vehicle yellow and pedestrian blinking-green length, in ticks (≥1).
- `T_PIETONI`, default 15: pedestrian steady-green length, in ticks (≥1).
- `CNT_W`, default 5: tick counter width; must hold max(T_*)−1.
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `clk_div` input 1: slow time-base tick; a one-`clk`-cycle enable pulse.
- `clk_div_int` input 1: blink tick; a one-`clk`-cycle enable pulse.
- `stare_semafor` input 3: phase code. 000 SUD, 001 EST, 010 VEST, 011 NORD, 100 PIETONI, 111 SERVICE. Codes 101 and 110 are invalid.
- `ready_S` output 1: one-cycle pulse when the commanded phase has completed.
- `semafor_S`, `semafor_E`, `semafor_V`, `semafor_N` output 3 each: lamps as {rosu, galben, verde}.
- `pietoni` output 2: pedestrian lamps as {rosu, verde}.

## Operation
- States: CLEAR, VERDE, GALBEN, DONE, SERVICE. Registers: state, `cnt`, latched code `cod`, `blink`.
- Reset: state=CLEAR, cnt=0, cod=SUD, blink=0. Outputs are all vehicle heads 100, `pietoni`=10, `ready_S`=0.
- CLEAR: all vehicle heads 100, `pietoni` 10.
  - `cnt` increments on each `clk_div`.
  - On the `clk_div` cycle with cnt==T_ROSU−1, sample `stare_semafor` into `cod` and clear `cnt`.
  - If the code is SERVICE, go to SERVICE.
  - If the code is 101 or 110, stay in CLEAR and restart the clearance.
  - Otherwise go to VERDE.
- VERDE:
  - Vehicle phase: the head selected by `cod` shows 001; all other heads 100; `pietoni` 10. Ends after T_VERDE ticks.
  - PIETONI: all vehicle heads 100; `pietoni` 01. Ends after T_PIETONI ticks.
  - On end, go to GALBEN with cnt=0.
- GALBEN:
  - Vehicle phase: the selected head shows 010; others 100.
  - PIETONI: vehicles 100; `pietoni` = {0, blink}.
    - blink is set to 1 on entry.
    - blink toggles on each `clk_div_int`.
  - Ends after T_GALBEN ticks, then go to DONE.
- DONE: lamps as in CLEAR. `ready_S`=1 for exactly this one cycle, then go to CLEAR with cnt=0.
- SERVICE: every vehicle head shows {0, blink, 0}; `pietoni`=00.
  - blink is set to 1 on entry and toggles on `clk_div_int`.
  - `stare_semafor` is sampled every `clk` cycle. When it is not 111, go to CLEAR with cnt=0 and blink=0.
  - `ready_S` is never asserted in SERVICE.
- `stare_semafor` changes are ignored outside CLEAR exit and SERVICE. A mid-phase code change never shortens or alters the running phase.
- A `clk_div` and a `clk_div_int` in the same cycle are both honoured independently.
- `rst` asserted in any state returns to the reset condition at the next edge and overrides every other event.

## Timing
- All outputs are registered. They are decoded from the next state, so lamps change on the same edge as the state register.
- A phase of length T ends on the edge after the T-th `clk_div` pulse counted in that state. The `clk_div` that causes entry is not counted.
- `ready_S` rises on the edge after the last GALBEN tick. It is high for 1 `clk` cycle.
- Full cycle, for a vehicle phase: T_ROSU + T_VERDE + T_GALBEN ticks, plus 1 `clk` cycle for DONE.
- Leaving SERVICE: all-red appears 1 `clk` cycle after `stare_semafor` becomes ≠111.

## Test plan
Settings for all scenarios: T_ROSU=2, T_VERDE=3, T_GALBEN=2, T_PIETONI=4, with `clk_div` every 4 `clk` cycles.

- **Reset and EST phase.** Hold `rst` for 3 cycles with `stare_semafor`=001.
  - Required: all heads 100 for 2 ticks.
  - Then `semafor_E`=001 for 3 ticks and `semafor_E`=010 for 2 ticks.
  - Then a single `ready_S` pulse, followed by all-red.
- **Pedestrian phase.** `stare_semafor`=100, with `clk_div_int` every 2 cycles.
  - Required: vehicles stay 100 throughout.
  - `pietoni`=01 for 4 ticks.
  - Then `pietoni` verde toggles 1,0,1… for 2 ticks, with `pietoni[1]`=0.
  - Then `ready_S` pulses once.
- **SERVICE entry and exit.** `stare_semafor`=111.
  - Required: after clearance, all heads show galben=blink, starting at 1 and toggling per `clk_div_int`; `pietoni`=00; `ready_S` never asserted.
  - Switch the code to 010: all heads 100 on the next cycle, then VEST proceeds after 2 ticks.
- **Mid-phase code change.** Switch SUD to NORD during VERDE.
  - Required: `semafor_S` completes 3+2 ticks unchanged.
  - NORD runs only after the next clearance.
- **Invalid code.** `stare_semafor`=101.
  - Required: CLEAR repeats indefinitely, all-red, with no `ready_S`.
- **Reset mid-GALBEN and simultaneous ticks.**
  - Assert `rst` during EST yellow. Required: all heads 100 and `ready_S`=0 on the next edge.
  - Coincident `clk_div` and `clk_div_int` in pedestrian GALBEN. Required: both count and toggle in that same cycle.

Source files
------------

// File: rtl/lumini_semafor.sv
// lumini_semafor -- traffic-light phase driver for one intersection.
//
// Takes the phase code chosen by the phase sequencer and runs one full phase:
// an all-red clearance, then green and yellow for the selected vehicle
// approach. For the pedestrian code it runs a steady pedestrian green followed
// by a blinking green instead. When the phase is finished it pulses ready_S
// back to the sequencer. The SERVICE code blinks every vehicle head yellow
// until a different code is presented.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   clk_div        slow time-base tick (one-clk enable pulse); all phase
//                  lengths are counted in these ticks
//   clk_div_int    blink tick (one-clk enable pulse)
//   stare_semafor  phase code: 000 SUD, 001 EST, 010 VEST, 011 NORD,
//                  100 PIETONI, 111 SERVICE (101/110 invalid)
//   ready_S        one-cycle pulse when the commanded phase has completed
//   semafor_S/E/V/N vehicle heads as {rosu, galben, verde}
//   pietoni        pedestrian head as {rosu, verde}
module lumini_semafor #(
  parameter int T_ROSU    = 2,
  parameter int T_VERDE   = 10,
  parameter int T_GALBEN  = 3,
  parameter int T_PIETONI = 15,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic       clk_div_int,
  input  logic [2:0] stare_semafor,
  output logic       ready_S,
  output logic [2:0] semafor_S,
  output logic [2:0] semafor_E,
  output logic [2:0] semafor_V,
  output logic [2:0] semafor_N,
  output logic [1:0] pietoni
);

  typedef enum logic [2:0] {CLEAR, VERDE, GALBEN, DONE, SERVICE} state_t;

  localparam logic [2:0] COD_SUD     = 3'b000;
  localparam logic [2:0] COD_PIETONI = 3'b100;
  localparam logic [2:0] COD_SERVICE = 3'b111;

  localparam logic [2:0] HEAD_RED    = 3'b100;
  localparam logic [2:0] HEAD_YELLOW = 3'b010;
  localparam logic [2:0] HEAD_GREEN  = 3'b001;

  // Terminal counts: a phase of length T ends on its T-th tick.
  localparam logic [CNT_W-1:0] LAST_ROSU    = CNT_W'(T_ROSU - 1);
  localparam logic [CNT_W-1:0] LAST_VERDE   = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0] LAST_GALBEN  = CNT_W'(T_GALBEN - 1);
  localparam logic [CNT_W-1:0] LAST_PIETONI = CNT_W'(T_PIETONI - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       cod, cod_n;
  logic             blink, blink_n;
  logic [CNT_W-1:0] verde_last;

  logic [2:0] s_n, e_n, v_n, n_n, head_sel;
  logic [1:0] pietoni_n;

  // Registers, including the lamp outputs. Lamps are decoded from the next
  // state, so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      cod       <= COD_SUD;
      blink     <= 1'b0;
      ready_S   <= 1'b0;
      semafor_S <= HEAD_RED;
      semafor_E <= HEAD_RED;
      semafor_V <= HEAD_RED;
      semafor_N <= HEAD_RED;
      pietoni   <= 2'b10;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cod       <= cod_n;
      blink     <= blink_n;
      ready_S   <= (state_n == DONE);
      semafor_S <= s_n;
      semafor_E <= e_n;
      semafor_V <= v_n;
      semafor_N <= n_n;
      pietoni   <= pietoni_n;
    end
  end

  // Next-state logic. The phase code is only looked at when the clearance
  // expires and while in SERVICE, so a mid-phase change cannot disturb a
  // running phase.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cod_n      = cod;
    blink_n    = blink;
    verde_last = (cod == COD_PIETONI) ? LAST_PIETONI : LAST_VERDE;

    case (state)
      CLEAR: begin
        if (clk_div) begin
          if (cnt == LAST_ROSU) begin
            cnt_n = '0;
            cod_n = stare_semafor;
            if (stare_semafor == COD_SERVICE) begin
              state_n = SERVICE;
              blink_n = 1'b1;
            end else if (stare_semafor == 3'b101 || stare_semafor == 3'b110) begin
              // Invalid code: hold all-red and start another clearance.
              state_n = CLEAR;
            end else begin
              state_n = VERDE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      VERDE: begin
        if (clk_div) begin
          if (cnt == verde_last) begin
            state_n = GALBEN;
            cnt_n   = '0;
            blink_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      GALBEN: begin
        // Blink and time base are independent; both may act in one cycle.
        if (clk_div_int) begin
          blink_n = ~blink;
        end
        if (clk_div) begin
          if (cnt == LAST_GALBEN) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end

      SERVICE: begin
        if (stare_semafor != COD_SERVICE) begin
          state_n = CLEAR;
          cnt_n   = '0;
          blink_n = 1'b0;
        end else if (clk_div_int) begin
          blink_n = ~blink;
        end
      end

      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase
  end

  // Lamp decode from the next state, code and blink bit.
  always_comb begin
    s_n       = HEAD_RED;
    e_n       = HEAD_RED;
    v_n       = HEAD_RED;
    n_n       = HEAD_RED;
    pietoni_n = 2'b10;
    head_sel  = (state_n == VERDE) ? HEAD_GREEN : HEAD_YELLOW;

    case (state_n)
      VERDE, GALBEN: begin
        if (cod_n == COD_PIETONI) begin
          pietoni_n = (state_n == VERDE) ? 2'b01 : {1'b0, blink_n};
        end else begin
          case (cod_n[1:0])
            2'd0:    s_n = head_sel;
            2'd1:    e_n = head_sel;
            2'd2:    v_n = head_sel;
            default: n_n = head_sel;
          endcase
        end
      end

      SERVICE: begin
        s_n       = {1'b0, blink_n, 1'b0};
        e_n       = {1'b0, blink_n, 1'b0};
        v_n       = {1'b0, blink_n, 1'b0};
        n_n       = {1'b0, blink_n, 1'b0};
        pietoni_n = 2'b00;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_lumini_semafor.sv
// tb_lumini_semafor -- directed, self-checking bench for lumini_semafor.
//
// Runs with T_ROSU=2, T_VERDE=3, T_GALBEN=2, T_PIETONI=4 and a clk_div pulse
// every 4 clk cycles. Every check compares the full lamp picture
// {S, E, V, N, pietoni, ready_S} against a hand-computed value.
module tb_lumini_semafor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_div = 1'b0;
  logic       clk_div_int = 1'b0;
  logic [2:0] stare_semafor = 3'b001;
  logic       ready_S;
  logic [2:0] semafor_S, semafor_E, semafor_V, semafor_N;
  logic [1:0] pietoni;

  int checkCount = 0;
  int passCount  = 0;
  int readyCount = 0;
  int rc;

  lumini_semafor #(
    .T_ROSU   (2),
    .T_VERDE  (3),
    .T_GALBEN (2),
    .T_PIETONI(4),
    .CNT_W    (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_div      (clk_div),
    .clk_div_int  (clk_div_int),
    .stare_semafor(stare_semafor),
    .ready_S      (ready_S),
    .semafor_S    (semafor_S),
    .semafor_E    (semafor_E),
    .semafor_V    (semafor_V),
    .semafor_N    (semafor_N),
    .pietoni      (pietoni)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with ready_S high, to prove single pulses and absences.
  always @(posedge clk) begin
    if (ready_S === 1'b1) readyCount <= readyCount + 1;
  end

  function automatic logic [14:0] expLamps(input logic [2:0] s, input logic [2:0] e,
                                           input logic [2:0] v, input logic [2:0] n,
                                           input logic [1:0] p, input logic r);
    return {s, e, v, n, p, r};
  endfunction

  function automatic logic [14:0] lamps();
    return {semafor_S, semafor_E, semafor_V, semafor_N, pietoni, ready_S};
  endfunction

  task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  // One clk cycle with the given tick inputs; outputs sampled 1 ns after the edge.
  task automatic applyStimulus(input logic div, input logic dint);
    clk_div     = div;
    clk_div_int = dint;
    @(posedge clk);
    #1;
    clk_div     = 1'b0;
    clk_div_int = 1'b0;
  endtask

  // One time-base period: clk_div on the 4th cycle, optional blink on cycles 2 and 4.
  task automatic divTick(input int n, input logic withInt);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(i == 3, withInt && (i % 2 == 1));
      end
    end
  endtask

  initial begin
    // Reset and EST phase
    rst = 1'b1;
    stare_semafor = 3'b001;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    rst = 1'b0;
    divTick(1, 1'b0);
    checkOutput("est_clear1", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("est_green", lamps(), expLamps(R, G, R, R, 2'b10, 1'b0));
    divTick(2, 1'b0);
    checkOutput("est_green_last", lamps(), expLamps(R, G, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("est_yellow", lamps(), expLamps(R, Y, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("est_yellow_last", lamps(), expLamps(R, Y, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("est_ready", lamps(), expLamps(R, R, R, R, 2'b10, 1'b1));
    applyStimulus(1'b0, 1'b0);
    checkOutput("est_ready_width", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));

    // Pedestrian phase, blink tick every 2 cycles
    stare_semafor = 3'b100;
    rc = readyCount;
    divTick(2, 1'b1);
    checkOutput("ped_green", lamps(), expLamps(R, R, R, R, 2'b01, 1'b0));
    divTick(3, 1'b1);
    checkOutput("ped_green_last", lamps(), expLamps(R, R, R, R, 2'b01, 1'b0));
    divTick(1, 1'b1);
    checkOutput("ped_blink_entry", lamps(), expLamps(R, R, R, R, 2'b01, 1'b0));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ped_blink_off", lamps(), expLamps(R, R, R, R, 2'b00, 1'b0));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ped_coincident_toggle", lamps(), expLamps(R, R, R, R, 2'b01, 1'b0));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ped_blink_off2", lamps(), expLamps(R, R, R, R, 2'b00, 1'b0));
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ped_ready", lamps(), expLamps(R, R, R, R, 2'b10, 1'b1));
    applyStimulus(1'b0, 1'b0);
    checkOutput("ped_ready_count", 15'(readyCount - rc), 15'd1);

    // SERVICE entry and exit
    stare_semafor = 3'b111;
    rc = readyCount;
    divTick(2, 1'b0);
    checkOutput("svc_entry", lamps(), expLamps(Y, Y, Y, Y, 2'b00, 1'b0));
    applyStimulus(1'b0, 1'b1);
    checkOutput("svc_blink_off", lamps(), expLamps(O, O, O, O, 2'b00, 1'b0));
    applyStimulus(1'b0, 1'b1);
    checkOutput("svc_blink_on", lamps(), expLamps(Y, Y, Y, Y, 2'b00, 1'b0));
    divTick(1, 1'b0);
    checkOutput("svc_hold", lamps(), expLamps(Y, Y, Y, Y, 2'b00, 1'b0));
    stare_semafor = 3'b010;
    applyStimulus(1'b0, 1'b0);
    checkOutput("svc_exit", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    checkOutput("svc_no_ready", 15'(readyCount - rc), 15'd0);
    divTick(1, 1'b0);
    checkOutput("vest_clear1", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("vest_green", lamps(), expLamps(R, R, G, R, 2'b10, 1'b0));
    divTick(3, 1'b0);
    checkOutput("vest_yellow", lamps(), expLamps(R, R, Y, R, 2'b10, 1'b0));
    divTick(2, 1'b0);
    checkOutput("vest_ready", lamps(), expLamps(R, R, R, R, 2'b10, 1'b1));
    applyStimulus(1'b0, 1'b0);

    // Mid-phase code change SUD -> NORD
    stare_semafor = 3'b000;
    divTick(2, 1'b0);
    checkOutput("sud_green", lamps(), expLamps(G, R, R, R, 2'b10, 1'b0));
    stare_semafor = 3'b011;
    divTick(2, 1'b0);
    checkOutput("sud_green_hold", lamps(), expLamps(G, R, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("sud_yellow", lamps(), expLamps(Y, R, R, R, 2'b10, 1'b0));
    divTick(2, 1'b0);
    checkOutput("sud_ready", lamps(), expLamps(R, R, R, R, 2'b10, 1'b1));
    applyStimulus(1'b0, 1'b0);
    divTick(1, 1'b0);
    checkOutput("nord_clear1", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("nord_green", lamps(), expLamps(R, R, R, G, 2'b10, 1'b0));
    divTick(5, 1'b0);
    checkOutput("nord_ready", lamps(), expLamps(R, R, R, R, 2'b10, 1'b1));
    applyStimulus(1'b0, 1'b0);

    // Invalid code: clearance repeats with no ready_S
    stare_semafor = 3'b101;
    rc = readyCount;
    for (int t = 0; t < 6; t++) begin
      divTick(1, 1'b1);
      checkOutput("inv_clear", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    end
    checkOutput("inv_no_ready", 15'(readyCount - rc), 15'd0);
    stare_semafor = 3'b001;
    divTick(2, 1'b0);
    checkOutput("inv_recover_green", lamps(), expLamps(R, G, R, R, 2'b10, 1'b0));

    // Reset during EST yellow, with both ticks present on the reset edge
    divTick(3, 1'b0);
    checkOutput("rst_pre_yellow", lamps(), expLamps(R, Y, R, R, 2'b10, 1'b0));
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_mid_yellow", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    rst = 1'b0;
    divTick(1, 1'b0);
    checkOutput("rst_clear1", lamps(), expLamps(R, R, R, R, 2'b10, 1'b0));
    divTick(1, 1'b0);
    checkOutput("rst_restart_green", lamps(), expLamps(R, G, R, R, 2'b10, 1'b0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
